hazard_scoreboard: RTL

- Parametrised successor to the pipeline hazard/forwarding unit.
- Resolves decode-stage operand hazards against NUM_FW younger in-flight pipeline stages, with per-stage "value not ready" flags (generalised load-use).
- Adds a scoreboard for one multi-cycle mul/div unit: RAW, WAW and structural stalls, plus a saturating stall-cycle counter.
- Sits beside the decode stage. Its outputs drive the operand muxes and the decode/fetch stall.

---
 rtl/hazard_scoreboard.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Purpose: decode-side operand hazard resolver with forwarding from NUM_FW stages plus a scoreboard for one multi-cycle mul/div unit.
// Latency: forwarding selects and stall are combinational (0 cycles); a mul/div issued at edge T completes MD_LAT cycles later.
// Backpressure: stall holds decode/fetch; a structural stall blocks a new mul/div issue until the done cycle of the current op.
//
// Ports:
//   clk, resetn                      clock (rising edge), async active-low reset
//   d_valid, rs, rt, use_rs, use_rt  decode slot and its source operands
//   d_rd, d_is_md                    decode destination and mul/div start flag
//   fw_rd/fw_val/fw_wen/fw_rdy       per-stage forwarding info; stage 0 is youngest
//   md_result                        mul/div result, meaningful while md_done
//   clr_stats                        synchronous clear of stall_cnt
//   stall                            hold decode/fetch and inject a bubble
//   v1_mux/v1_fw, v2_mux/v2_fw       forwarding select and value for rs/rt
//   md_busy, md_done, md_rd          mul/div scoreboard state
//   stall_cnt                        saturating stall-cycle counter
module hazard_scoreboard #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_FW = 2,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       d_valid,
  input  logic [REG_AW-1:0]          rs,
  input  logic [REG_AW-1:0]          rt,
  input  logic                       use_rs,
  input  logic                       use_rt,
  input  logic [REG_AW-1:0]          d_rd,
  input  logic                       d_is_md,
  input  logic [NUM_FW*REG_AW-1:0]   fw_rd,
  input  logic [NUM_FW*DATA_W-1:0]   fw_val,
  input  logic [NUM_FW-1:0]          fw_wen,
  input  logic [NUM_FW-1:0]          fw_rdy,
  input  logic [DATA_W-1:0]          md_result,
  input  logic                       clr_stats,
  output logic                       stall,
  output logic                       v1_mux,
  output logic                       v2_mux,
  output logic [DATA_W-1:0]          v1_fw,
  output logic [DATA_W-1:0]          v2_fw,
  output logic                       md_busy,
  output logic                       md_done,
  output logic [REG_AW-1:0]          md_rd,
  output logic [CNT_W-1:0]           stall_cnt
);

  // Countdown only needs to hold MD_LAT-1 .. 0.
  localparam int                CD_W    = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam logic [CD_W-1:0]   CD_LOAD = CD_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // Result of resolving one source operand.
  typedef struct packed {
    logic              sel;      // some source supplies the operand
    logic              wait_ld;  // winning stage has no value yet
    logic [DATA_W-1:0] val;
  } src_t;

  logic              md_busy_q, md_busy_d;
  logic [REG_AW-1:0] md_rd_q,   md_rd_d;
  logic [CD_W-1:0]   cd_q,      cd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  src_t src1, src2;
  logic md_pending;
  logic raw_stall, waw_stall, str_stall, ld_stall;
  logic stall_c, issue;

  // Walk stages oldest to youngest so the youngest match overwrites older ones;
  // a not-ready youngest match therefore stalls rather than falling back to an
  // older, stale value. The mul/div writeback is only a source when no stage
  // claims the register.
  function automatic src_t resolve(
    input logic                      use_x,
    input logic [REG_AW-1:0]         x,
    input logic [NUM_FW*REG_AW-1:0]  rd_v,
    input logic [NUM_FW*DATA_W-1:0]  val_v,
    input logic [NUM_FW-1:0]         wen_v,
    input logic [NUM_FW-1:0]         rdy_v,
    input logic                      done,
    input logic [REG_AW-1:0]         mrd,
    input logic [DATA_W-1:0]         mres
  );
    src_t s;
    s = '0;
    for (int i = NUM_FW - 1; i >= 0; i--) begin
      if (use_x && (x != '0) && wen_v[i] && (rd_v[i*REG_AW +: REG_AW] == x)) begin
        s.sel     = 1'b1;
        s.wait_ld = !rdy_v[i];
        s.val     = val_v[i*DATA_W +: DATA_W];
      end
    end
    if (!s.sel && done && (mrd == x) && (x != '0)) begin
      s.sel = 1'b1;
      s.val = mres;
    end
    return s;
  endfunction

  assign md_done    = md_busy_q && (cd_q == '0);
  // Op still computing: its result cannot be forwarded yet.
  assign md_pending = md_busy_q && !md_done;

  always_comb begin
    src1 = resolve(use_rs, rs, fw_rd, fw_val, fw_wen, fw_rdy, md_done, md_rd_q, md_result);
    src2 = resolve(use_rt, rt, fw_rd, fw_val, fw_wen, fw_rdy, md_done, md_rd_q, md_result);

    ld_stall  = src1.wait_ld || src2.wait_ld;
    raw_stall = md_pending &&
                ((use_rs && (rs != '0) && (rs == md_rd_q)) ||
                 (use_rt && (rt != '0) && (rt == md_rd_q)));
    waw_stall = md_pending && (d_rd != '0) && (d_rd == md_rd_q);
    str_stall = md_pending && d_is_md;

    stall_c = d_valid && (ld_stall || raw_stall || waw_stall || str_stall);
    issue   = d_valid && d_is_md && !stall_c;
  end

  always_comb begin
    md_busy_d = md_busy_q;
    md_rd_d   = md_rd_q;
    cd_d      = cd_q;
    // Issue in the done cycle reloads the countdown so md_busy never drops.
    if (issue) begin
      md_busy_d = 1'b1;
      md_rd_d   = d_rd;
      cd_d      = CD_LOAD;
    end else if (md_busy_q) begin
      if (cd_q != '0) begin
        cd_d = cd_q - CD_W'(1);
      end else begin
        md_busy_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
    end else if (stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md_busy_q   <= 1'b0;
      md_rd_q     <= '0;
      cd_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_busy_q   <= md_busy_d;
      md_rd_q     <= md_rd_d;
      cd_q        <= cd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall     = stall_c;
  assign v1_mux    = src1.sel;
  assign v1_fw     = src1.val;
  assign v2_mux    = src2.sel;
  assign v2_fw     = src2.val;
  assign md_busy   = md_busy_q;
  assign md_rd     = md_rd_q;
  assign stall_cnt = stall_cnt_q;

endmodule
